// File: rtl/time_slice_pkg.sv
// Shared encodings, reset defaults and parameter sanity check for the
// time-slice scheduler.
package time_slice_pkg;

    typedef enum logic [1:0] {
        CFG_SEL_TOTAL = 2'd0,
        CFG_SEL_START = 2'd1,
        CFG_SEL_END   = 2'd2,
        CFG_SEL_MASK  = 2'd3
    } cfg_sel_e;

    // Wide defaults, truncated to CNT_WIDTH at the point of use.
    localparam logic [63:0] RST_TOTAL = '1;
    localparam logic [63:0] RST_START = '0;
    localparam logic [63:0] RST_END   = '1;
    localparam logic        RST_MASK  = 1'b0;

    function automatic bit idx_width_ok(input int num_slice, input int idx_width);
        return (num_slice >= 1) && (num_slice <= 16) && (num_slice <= (1 << idx_width));
    endfunction

endpackage

// File: rtl/time_slice_window.sv
// Combinational window test for one slice; s > e denotes a window that
// wraps across the period boundary.
module time_slice_window #(
    parameter int CNT_WIDTH = 25
) (
    input  logic [CNT_WIDTH-1:0] count,
    input  logic [CNT_WIDTH-1:0] win_start,
    input  logic [CNT_WIDTH-1:0] win_end,
    input  logic                 mask,
    output logic                 hit
);

    logic in_win;

    always_comb begin
        in_win = 1'b0;
        if (win_start <= win_end)
            in_win = (count >= win_start) && (count <= win_end);
        else
            in_win = (count >= win_start) || (count <= win_end);
    end

    assign hit = mask && in_win;

endmodule

// File: rtl/time_slice_sched.sv
// N-slice time-division scheduler: resyncable period counter, double-buffered
// per-slice windows applied atomically at period boundaries.
module time_slice_sched
    import time_slice_pkg::*;
#(
    parameter int NUM_SLICE   = 4,
    parameter int IDX_WIDTH   = 4,
    parameter int CNT_WIDTH   = 25,
    parameter int TIMER_WIDTH = 64
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [TIMER_WIDTH-1:0] tsf_runtime_val,
    input  logic                   beacon_end_rx,
    input  logic                   cfg_wr_en,
    input  logic [1:0]             cfg_sel,
    input  logic [IDX_WIDTH-1:0]   cfg_idx,
    input  logic [CNT_WIDTH-1:0]   cfg_data,
    input  logic                   cfg_commit,
    output logic                   commit_pending,
    output logic                   period_start,
    output logic [CNT_WIDTH-1:0]   counter_val,
    output logic [NUM_SLICE-1:0]   slice_en
);

    if (!idx_width_ok(NUM_SLICE, IDX_WIDTH)) begin : g_bad_cfg
        $error("time_slice_sched: NUM_SLICE must be 1..16 and fit in IDX_WIDTH");
    end

    logic [CNT_WIDTH-1:0] counter_reg;
    logic [CNT_WIDTH-1:0] shadow_total_reg;
    logic [CNT_WIDTH-1:0] active_total_reg;
    logic                 commit_pending_reg;
    logic                 period_start_reg;
    logic [NUM_SLICE-1:0] slice_en_reg;
    logic [NUM_SLICE-1:0] hit;
    logic                 boundary;
    logic                 transfer;
    cfg_sel_e             sel;

    assign sel      = cfg_sel_e'(cfg_sel);
    // The >= compare also catches a committed total smaller than the count.
    assign boundary = beacon_end_rx || (tsf_runtime_val == '0) ||
                      (counter_reg >= active_total_reg);
    assign transfer = boundary && (commit_pending_reg || cfg_commit);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            counter_reg        <= '0;
            period_start_reg   <= 1'b0;
            slice_en_reg       <= '0;
            commit_pending_reg <= 1'b0;
            shadow_total_reg   <= CNT_WIDTH'(RST_TOTAL);
            active_total_reg   <= CNT_WIDTH'(RST_TOTAL);
        end else begin
            counter_reg      <= boundary ? '0 : counter_reg + 1'b1;
            period_start_reg <= boundary;
            slice_en_reg     <= hit;
            if (transfer)
                commit_pending_reg <= 1'b0;
            else if (cfg_commit)
                commit_pending_reg <= 1'b1;
            if (cfg_wr_en && sel == CFG_SEL_TOTAL)
                shadow_total_reg <= cfg_data;
            if (transfer)
                active_total_reg <= shadow_total_reg;
        end
    end

    // Per-slice register banks live inside the generate scope; an index
    // beyond NUM_SLICE-1 matches no slice, so such writes are dropped.
    for (genvar gi = 0; gi < NUM_SLICE; gi++) begin : g_slice
        logic [CNT_WIDTH-1:0] shadow_start_reg, shadow_end_reg;
        logic [CNT_WIDTH-1:0] active_start_reg, active_end_reg;
        logic                 shadow_mask_reg, active_mask_reg;
        logic                 slice_wr;

        assign slice_wr = cfg_wr_en && (cfg_idx == IDX_WIDTH'(gi));

        always_ff @(posedge clk) begin
            if (!rstn) begin
                shadow_start_reg <= CNT_WIDTH'(RST_START);
                shadow_end_reg   <= CNT_WIDTH'(RST_END);
                shadow_mask_reg  <= RST_MASK;
                active_start_reg <= CNT_WIDTH'(RST_START);
                active_end_reg   <= CNT_WIDTH'(RST_END);
                active_mask_reg  <= RST_MASK;
            end else begin
                if (slice_wr) begin
                    case (sel)
                        CFG_SEL_START: shadow_start_reg <= cfg_data;
                        CFG_SEL_END:   shadow_end_reg   <= cfg_data;
                        CFG_SEL_MASK:  shadow_mask_reg  <= cfg_data[0];
                        default: ;
                    endcase
                end
                // Active copy takes the pre-write shadow on a same-cycle write.
                if (transfer) begin
                    active_start_reg <= shadow_start_reg;
                    active_end_reg   <= shadow_end_reg;
                    active_mask_reg  <= shadow_mask_reg;
                end
            end
        end

        time_slice_window #(
            .CNT_WIDTH (CNT_WIDTH)
        ) u_window (
            .count     (counter_reg),
            .win_start (active_start_reg),
            .win_end   (active_end_reg),
            .mask      (active_mask_reg),
            .hit       (hit[gi])
        );
    end

    assign commit_pending = commit_pending_reg;
    assign period_start   = period_start_reg;
    assign counter_val    = counter_reg;
    assign slice_en       = slice_en_reg;

endmodule
